muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_iter_dp.sv | 84 ++++++++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide sequencer:
//   - XLEN            default operand/result width
//   - md_state_e      sequencer FSM states (IDLE, CALC, DONE)
//   - F3_*            funct3 encodings of the eight M-extension operations
//   - is_signed_a/b   which operand is treated as two's complement per op
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // rs1 is signed for everything except the purely unsigned ops.
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    // rs2 is signed only for the signed x signed multiplies and signed divides.
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp
// Iterative datapath shared by multiply and divide. Works on unsigned
// magnitudes; the sequencer handles signs.
//   Multiply: {hi,lo} starts as {0, a}; each step conditionally adds b into hi
//             and shifts the whole pair right by one (shift-add).
//   Divide:   {hi,lo} starts as {0, a}; each step shifts the pair left by one
//             and does a restoring subtract of b from hi, shifting the
//             quotient bit into lo. After XLEN steps hi = remainder, lo = quotient.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   load              capture a_mag/b_mag and clear hi
//   step              perform one iteration
//   is_div            1 = divide step, 0 = multiply step
//   a_mag, b_mag      operand magnitudes
//   next_hi, next_lo  value {hi,lo} will hold after the current step, so the
//                     sequencer can latch the final result without waiting
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] next_hi,
    output logic [XLEN-1:0] next_lo
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;

    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;

    // One iteration of either algorithm. The multiply sum keeps its carry so
    // it shifts back into hi; the divide compare uses the shifted-out bit so
    // partial remainders up to 2*b are handled without a wider subtractor.
    always_comb begin
        addend  = lo_q[0] ? b_q : '0;
        sum     = {1'b0, hi_q} + {1'b0, addend};
        shifted = {hi_q, lo_q[XLEN-1]};
        fits    = (shifted >= {1'b0, b_q});
        diff    = shifted[XLEN-1:0] - b_q;
        next_hi = hi_q;
        next_lo = lo_q;
        if (is_div) begin
            if (fits) begin
                next_hi = diff;
                next_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                next_hi = shifted[XLEN-1:0];
                next_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[XLEN:1];
            next_lo = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Accumulator/shift registers: load wins over step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= a_mag;
            b_q  <= b_mag;
        end else if (step) begin
            hi_q <= next_hi;
            lo_q <= next_lo;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// EX-stage sequencer for RV32M multiply/divide. Stalls the front of the
// pipeline while a XLEN-step shift-add / restoring-divide runs in
// muldiv_iter_dp, then presents the sign-corrected result for one cycle.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   startE         valid M-extension instruction in EX
//   funct3E        operation select (MUL..REMU)
//   SrcAE, SrcBE   forwarded rs1 / rs2
//   FlushE         squash the EX instruction (aborts any operation)
//   StallMDE       stall request for IF/ID/EX
//   DoneE          MDResultE valid this cycle
//   MDResultE      result; holds its last value outside DONE
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMDE,
    output logic            DoneE,
    output logic [XLEN-1:0] MDResultE
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             sa_q;
    logic             sb_q;
    logic [XLEN-1:0]  res_q;

    logic             start_ok;
    logic             sign_a;
    logic             sign_b;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [XLEN-1:0]  special_res;

    logic             dp_step;
    logic [XLEN-1:0]  next_hi;
    logic [XLEN-1:0]  next_lo;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    // Accept a new operation only from IDLE; a flush in the same cycle wins.
    assign start_ok = (state_q == IDLE) && startE && !FlushE;

    // Operand decode at start: signs, magnitudes and the two cases that
    // bypass iteration. The results of those cases come straight from the
    // raw operands, so they never need sign fix-up.
    always_comb begin
        sign_a   = is_signed_a(funct3E) && SrcAE[XLEN-1];
        sign_b   = is_signed_b(funct3E) && SrcBE[XLEN-1];
        a_mag    = sign_a ? -SrcAE : SrcAE;
        b_mag    = sign_b ? -SrcBE : SrcBE;
        div_zero = funct3E[2] && (SrcBE == '0);
        div_ovf  = ((funct3E == F3_DIV) || (funct3E == F3_REM))
                   && (SrcAE == INT_MIN) && (SrcBE == '1);
        special  = div_zero || div_ovf;
        if (funct3E[1]) begin
            special_res = div_zero ? SrcAE : '0;
        end else begin
            special_res = div_zero ? '1 : SrcAE;
        end
    end

    assign dp_step = (state_q == CALC) && !FlushE;

    muldiv_iter_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_ok),
        .step    (dp_step),
        .is_div  (op_q[2]),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .next_hi (next_hi),
        .next_lo (next_lo)
    );

    // Sign fix-up on the value the datapath produces in its last step, so
    // the result register is ready on the first DONE cycle.
    always_comb begin
        prod     = {next_hi, next_lo};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quot_fix = (sa_q ^ sb_q) ? -next_lo : next_lo;
        rem_fix  = sa_q ? -next_hi : next_hi;
        case (op_q)
            F3_MUL:                        final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_res = quot_fix;
            default:                       final_res = rem_fix;
        endcase
    end

    // Next-state logic. Flush aborts from any state; DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startE && !FlushE) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (FlushE) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation context, iteration counter and result register. The result
    // only changes when entering DONE, so it holds its value everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= F3_MUL;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            res_q <= '0;
        end else if (start_ok) begin
            op_q  <= funct3E;
            sa_q  <= sign_a;
            sb_q  <= sign_b;
            cnt_q <= CNT_W'(XLEN - 1);
            if (special) begin
                res_q <= special_res;
            end
        end else if (dp_step) begin
            if (cnt_q == '0) begin
                res_q <= final_res;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Both handshake outputs are forced low while reset is asserted.
    assign StallMDE  = rst_n && ((state_q == CALC) || start_ok);
    assign DoneE     = rst_n && (state_q == DONE);
    assign MDResultE = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Bench for muldiv_sequencer (XLEN=32). A behavioural model computes each
// operation's result with plain 64-bit arithmetic and its completion cycle
// from the operands; a negedge process compares StallMDE, DoneE and
// MDResultE against it every cycle. Directed operations additionally pin
// both model and DUT to hand-computed results and latencies.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        StallMDE;
    logic        DoneE;
    logic [31:0] MDResultE;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit          m_active = 1'b0;
    int          m_t0     = 0;
    int          m_lat    = 0;
    logic [31:0] m_exp    = '0;
    logic [31:0] m_last   = '0;
    logic        exp_stall;
    logic        exp_done;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .startE    (startE),
        .funct3E   (funct3E),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .StallMDE  (StallMDE),
        .DoneE     (DoneE),
        .MDResultE (MDResultE)
    );

    // Architectural result of an M-extension op, from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (f)
            F3_MUL:    begin sp = sa * sb; r = sp[31:0]; end
            F3_MULH:   begin sp = sa * sb; r = sp[63:32]; end
            F3_MULHSU: begin sp = sa * longint'({32'b0, b}); r = sp[63:32]; end
            F3_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin sp = sa / sb; r = sp[31:0]; end
            end
            F3_DIVU:   r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            F3_REM: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin sp = sa % sb; r = sp[31:0]; end
            end
            default:   r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycles from the start cycle to the DoneE cycle.
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == F3_DIV || f == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model update on each rising edge, from the same inputs the DUT samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_last   = '0;
        end else if (m_active) begin
            if (FlushE) begin
                m_active = 1'b0;
            end else begin
                if (cyc == m_t0 + m_lat - 1) m_last = m_exp;
                if (cyc == m_t0 + m_lat) m_active = 1'b0;
            end
        end else if (startE && !FlushE) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_lat    = ref_latency(funct3E, SrcAE, SrcBE);
            m_exp    = ref_result(funct3E, SrcAE, SrcBE);
            if (m_lat == 1) m_last = m_exp;
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        exp_stall = rst_n && ((m_active && cyc < m_t0 + m_lat) || (!m_active && startE && !FlushE));
        exp_done  = rst_n && m_active && (cyc == m_t0 + m_lat);
        checkOutput("cyc_stall", {31'b0, StallMDE}, {31'b0, exp_stall});
        checkOutput("cyc_done", {31'b0, DoneE}, {31'b0, exp_done});
        checkOutput("cyc_result", MDResultE, m_last);
    end

    // Start an op at the current cycle, hold startE until DoneE (bounded),
    // and leave at the following cycle with startE low.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
        int t0;
        bit seen;
        funct3E = f;
        SrcAE   = a;
        SrcBE   = b;
        startE  = 1'b1;
        t0      = cyc;
        seen    = 1'b0;
        res     = '0;
        lat     = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (DoneE === 1'b1) begin
                seen = 1'b1;
                res  = MDResultE;
                lat  = cyc - t0;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_timeout: got no DoneE, expected one within 40 cycles (op %0d)", f);
        end
        @(posedge clk);
        #1;
        startE = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int want_lat);
        logic [31:0] res;
        int          lat;
        checkOutput({name, "_model"}, ref_result(f, a, b), want);
        applyStimulus(f, a, b, res, lat);
        checkOutput({name, "_result"}, res, want);
        checkOutput({name, "_latency"}, lat, want_lat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        startE  = 1'b0;
        FlushE  = 1'b0;
        funct3E = 3'b000;
        SrcAE   = '0;
        SrcBE   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_result", MDResultE, 32'd0);
        checkOutput("reset_stall", {31'b0, StallMDE}, 32'd0);
        checkOutput("reset_done", {31'b0, DoneE}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] multiply cases");
        runOp("mul_7_m3",      F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        runOp("mulhu_m1_m1",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp("mulh_m1_m1",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        runOp("mulhsu_m1_2",   F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        runOp("mulh_min_min",  F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        runOp("mul_min_min",   F3_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 33);

        $display("[TB] divide special cases");
        runOp("divu_100_0",    F3_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1);
        runOp("rem_100_0",     F3_REM,    32'd100,      32'd0,        32'd100,      1);
        runOp("div_m5_0",      F3_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
        runOp("remu_7_0",      F3_REMU,   32'd7,        32'd0,        32'd7,        1);
        runOp("div_ovf",       F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        runOp("rem_ovf",       F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        $display("[TB] divide iterative cases");
        runOp("div_m7_2",      F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        runOp("rem_m7_2",      F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        runOp("div_20_m6",     F3_DIV,    32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 33);
        runOp("rem_20_m6",     F3_REM,    32'd20,       32'hFFFFFFFA, 32'd2,        33);
        runOp("remu_100_7",    F3_REMU,   32'd100,      32'd7,        32'd2,        33);
        runOp("divu_min_m1",   F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33);

        $display("[TB] flush during DIVU");
        funct3E = F3_DIVU;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd7;
        startE  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        startE = 1'b0;
        @(negedge clk);
        checkOutput("flush_stall", {31'b0, StallMDE}, 32'd0);
        checkOutput("flush_done", {31'b0, DoneE}, 32'd0);
        repeat (35) @(posedge clk);
        #1;
        runOp("divu_after_flush", F3_DIVU, 32'd1000, 32'd7, 32'd142, 33);

        $display("[TB] flush and start in the same cycle");
        funct3E = F3_MUL;
        SrcAE   = 32'd2;
        SrcBE   = 32'd3;
        startE  = 1'b1;
        FlushE  = 1'b1;
        @(negedge clk);
        checkOutput("startflush_stall", {31'b0, StallMDE}, 32'd0);
        @(posedge clk);
        #1;
        startE = 1'b0;
        FlushE = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset during MUL");
        funct3E = F3_MUL;
        SrcAE   = 32'd5;
        SrcBE   = 32'd6;
        startE  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n  = 1'b0;
        startE = 1'b0;
        @(negedge clk);
        checkOutput("inreset_stall", {31'b0, StallMDE}, 32'd0);
        checkOutput("inreset_done", {31'b0, DoneE}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset_result", MDResultE, 32'd0);
        checkOutput("postreset_stall", {31'b0, StallMDE}, 32'd0);
        checkOutput("postreset_done", {31'b0, DoneE}, 32'd0);
        @(posedge clk);
        #1;
        runOp("mul_3_4",   F3_MUL,  32'd3,  32'd4, 32'd12, 33);
        runOp("divu_12_5", F3_DIVU, 32'd12, 32'd5, 32'd2,  33);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
